dac_write_scheduler: RTL and testbench

- Shares the single serial DAC controller (start strobe `ctrl`, 16-bit word `dato`) between N_REQ independent requesters.
- Arbitrates round-robin, latches the winner's word and issues the one-cycle start strobe.
- Holds the word stable for a programmed frame time plus guard gap, then pulses `done` and re-arbitrates.
- Sits between the acquisition/control logic and the DAC serializer, in the same clock domain.

---
 rtl/dac_write_scheduler.sv | 129 ++++++++++++
 tb/tb_dac_write_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_scheduler.sv
// Round-robin scheduler that shares one serial DAC controller between N_REQ requesters.
// A granted word is held on dato through a strobe, a fixed frame window and a guard gap.
module dac_write_scheduler #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 48,
    parameter int GAP_CYCLES   = 4,
    localparam int CH_W        = $clog2(N_REQ)
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   data_in,
    output logic [N_REQ-1:0]      grant,
    output logic                  ctrl,
    output logic [15:0]           dato,
    output logic                  busy,
    output logic                  done,
    output logic [CH_W-1:0]       last_ch,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    logic             win_valid;
    logic [CH_W-1:0]  win_idx;
    logic [N_REQ-1:0] win_onehot;
    logic [15:0]      win_data;

    // Handshake: req is a level held by the requester; the one-cycle grant pulse
    // is the acceptance, after which the requester may drop req or change its word.

    // Pick the set request with the smallest distance above last_ch, wrapping.
    always_comb begin
        int off;
        int best_off;
        win_valid  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        best_off   = N_REQ;
        off        = 0;
        for (int j = 0; j < N_REQ; j++) begin
            off = (j + 2 * N_REQ - int'(last_ch) - 1) % N_REQ;
            if (req[j] && (off < best_off)) begin
                best_off      = off;
                win_valid     = 1'b1;
                win_idx       = CH_W'(j);
                win_onehot    = '0;
                win_onehot[j] = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = 16'h0000;
        for (int j = 0; j < N_REQ; j++) begin
            if (win_idx == CH_W'(j)) begin
                win_data = data_in[16*j +: 16];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            grant   <= '0;
            dato    <= 16'h0000;
            done    <= 1'b0;
            last_ch <= CH_W'(N_REQ - 1);
        end else begin
            grant <= '0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        state   <= S_LOAD;
                        grant   <= win_onehot;
                        dato    <= win_data;
                        last_ch <= win_idx;
                    end
                end
                S_LOAD: begin
                    state <= S_STROBE;
                end
                S_STROBE: begin
                    state <= S_WAIT;
                    cnt   <= FRAME_LOAD;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_GAP;
                        cnt   <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    // done is registered so it lands on the first IDLE cycle.
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl      = (state == S_STROBE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Bench for dac_write_scheduler: table of back-to-back writes plus hand-written
// sequences for dropped requests, data stability and reset mid-frame.
module tb_dac_write_scheduler;

    localparam int N   = 4;
    localparam int W   = N + 16;
    localparam int SPC = 48 + 4 + 3;
    localparam int DLY = 48 + 4 + 1;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] words;
        logic [3:0]  exp_grant;
        logic [15:0] exp_word;
        logic [1:0]  exp_last;
    } vec_t;

    logic          clk_in;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [16*N-1:0] data_in;
    logic [N-1:0]  grant;
    logic          ctrl;
    logic [15:0]   dato;
    logic          busy;
    logic          done;
    logic [1:0]    last_ch;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_ctrl_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [15:0]  pend_word = 16'h0000;
    vec_t vecs[12];

    dac_write_scheduler #(.N_REQ(N), .FRAME_CYCLES(48), .GAP_CYCLES(4)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant), .ctrl(ctrl), .dato(dato), .busy(busy), .done(done),
        .last_ch(last_ch), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every grant must match the head of exp_q
    always @(negedge clk_in) begin
        logic [W-1:0] e;
        if (rst_n === 1'b1) begin
            if (grant !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(grant), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_vs_expected", 32'(grant), 32'(e[W-1:16]));
                    check("dato_at_grant", 32'(dato), 32'(e[15:0]));
                    pend_word = e[15:0];
                end
            end
            if (ctrl === 1'b1) check("dato_at_ctrl", 32'(dato), 32'(pend_word));
        end
    end

    // driver: one complete write slot, from request to done
    task automatic run_slot(input vec_t v, input bit drop, input logic [3:0] pulse_mask,
                            input bit chg_en, input logic [63:0] chg_words, input bit chk_space);
        int n;
        bit err;
        exp_q.push_back({v.exp_grant, v.exp_word});
        req     = v.req;
        data_in = v.words;
        n = 0;
        @(negedge clk_in);
        while (grant == '0 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check("grant_latency", 32'(n), 32'd0);
        check("last_ch", 32'(last_ch), 32'(v.exp_last));
        if (drop) req = '0;
        if (chg_en) data_in = chg_words;
        @(negedge clk_in);
        check("ctrl_after_grant", 32'(ctrl), 32'd1);
        check("busy_in_strobe", 32'(busy), 32'd1);
        if (chk_space) check("ctrl_spacing", 32'(cyc - last_ctrl_cyc), 32'(SPC));
        last_ctrl_cyc = cyc;
        n   = 0;
        err = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk_in);
            n++;
            if (pulse_mask != '0) req = (n >= 5 && n < 8) ? pulse_mask : 4'b0000;
            if (!done && (busy !== 1'b1 || ctrl !== 1'b0 || grant !== '0)) err = 1'b1;
        end
        check("done_delay", 32'(n), 32'(DLY));
        check("busy_ctrl_during_slot", 32'(err), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
        check("dato_hold", 32'(dato), 32'(v.exp_word));
    endtask

    initial begin
        int n;
        bit err;
        vec_t v;
        vecs[0]  = '{4'b0100, 64'h0000_CAAA_0000_0000, 4'b0100, 16'hCAAA, 2'd2};
        vecs[1]  = '{4'b1111, 64'h4003_3002_2001_1000, 4'b1000, 16'h4003, 2'd3};
        vecs[2]  = '{4'b1111, 64'h4003_3002_2001_1000, 4'b0001, 16'h1000, 2'd0};
        vecs[3]  = '{4'b1111, 64'h4003_3002_2001_1000, 4'b0010, 16'h2001, 2'd1};
        vecs[4]  = '{4'b1111, 64'h4003_3002_2001_1000, 4'b0100, 16'h3002, 2'd2};
        vecs[5]  = '{4'b1111, 64'h4003_3002_2001_1000, 4'b1000, 16'h4003, 2'd3};
        vecs[6]  = '{4'b1111, 64'h4003_3002_2001_1000, 4'b0001, 16'h1000, 2'd0};
        vecs[7]  = '{4'b0010, 64'h4003_3002_2001_1000, 4'b0010, 16'h2001, 2'd1};
        vecs[8]  = '{4'b0011, 64'h4003_3002_2001_1000, 4'b0001, 16'h1000, 2'd0};
        vecs[9]  = '{4'b0011, 64'h4003_3002_2001_1000, 4'b0010, 16'h2001, 2'd1};
        vecs[10] = '{4'b1010, 64'h4003_3002_2001_1000, 4'b1000, 16'h4003, 2'd3};
        vecs[11] = '{4'b0001, 64'h4003_3002_2001_1000, 4'b0001, 16'h1000, 2'd0};

        rst_n   = 1'b0;
        req     = '0;
        data_in = '0;
        repeat (3) @(negedge clk_in);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_ctrl", 32'(ctrl), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_dato", 32'(dato), 32'h0);
        check("rst_last_ch", 32'(last_ch), 32'd3);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // table: single request, round-robin with wrap, fairness after skip
        for (int i = 0; i < 12; i++) begin
            run_slot(vecs[i], 1'b0, 4'b0000, 1'b0, 64'h0, i != 0);
        end

        // data stability plus a request pulsed and dropped while busy
        v = '{4'b0001, 64'h4003_3002_2001_00FF, 4'b0001, 16'h00FF, 2'd0};
        run_slot(v, 1'b1, 4'b1000, 1'b1, 64'h4003_3002_2001_FF00, 1'b1);
        err = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            if (grant !== '0 || ctrl !== 1'b0 || busy !== 1'b0) err = 1'b1;
        end
        check("no_grant_after_drop", 32'(err), 32'd0);
        check("dato_unchanged_idle", 32'(dato), 32'h00FF);
        check("last_ch_after_drop", 32'(last_ch), 32'd0);

        v = '{4'b0001, 64'h4003_3002_2001_FF00, 4'b0001, 16'hFF00, 2'd0};
        run_slot(v, 1'b1, 4'b0000, 1'b0, 64'h0, 1'b0);

        // reset in cycle 10 of WAIT
        exp_q.push_back({4'b0001, 16'h5A5A});
        data_in = 64'h0000_0000_0000_5A5A;
        req     = 4'b0001;
        n = 0;
        @(negedge clk_in);
        while (grant == '0 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check("mid_grant_latency", 32'(n), 32'd0);
        @(negedge clk_in);
        check("mid_ctrl", 32'(ctrl), 32'd1);
        repeat (10) @(negedge clk_in);
        check("mid_in_wait", 32'(dbg_state), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'(ctrl), 32'h0);
        check("mid_rst_dato", 32'(dato), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_last_ch", 32'(last_ch), 32'd3);
        repeat (2) @(negedge clk_in);
        check("mid_no_done_in_reset", 32'(done), 32'h0);
        exp_q.push_back({4'b0001, 16'h5A5A});
        rst_n = 1'b1;
        @(negedge clk_in);
        check("post_rst_grant", 32'(grant), 32'h1);
        check("post_rst_last_ch", 32'(last_ch), 32'd0);
        req = '0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        check("post_rst_done_seen", 32'(done), 32'd1);
        check("post_rst_dato", 32'(dato), 32'h5A5A);

        repeat (5) @(negedge clk_in);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
